// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending bits plus per-FU occupancy counters.
// Decides each cycle whether the IDU1 instruction may issue (RAW, WAW and
// structural hazards) and tracks in-flight destinations until writeback.
module issue_scoreboard #(
    parameter int unsigned NUM_REGS            = 32,
    parameter int unsigned REG_FILE_ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int unsigned NUM_FU              = 4,
    parameter int unsigned FU_W                = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    parameter logic [NUM_FU*4-1:0] FU_CAP      = {NUM_FU{4'd1}}
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           iss_valid,
    input  logic [FU_W-1:0]                iss_fu,
    input  logic                           iss_rs1_en,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] iss_rs1_addr,
    input  logic                           iss_rs2_en,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] iss_rs2_addr,
    input  logic                           iss_rd_en,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] iss_rd_addr,
    input  logic                           pipe_flush,
    input  logic                           wb_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [NUM_FU-1:0]              fu_done,
    output logic                           pipe_stall,
    output logic                           iss_fire,
    output logic [NUM_FU-1:0]              fu_busy,
    output logic [NUM_REGS-1:0]            pending,
    output logic                           sb_err
);

    logic [NUM_REGS-1:0]        pending_reg;
    logic [NUM_REGS-1:0]        pending_next;
    logic [NUM_REGS-1:0]        wb_hit;
    logic [NUM_REGS-1:0]        set_hit;
    logic [NUM_REGS-1:0]        pend_eff;
    logic [NUM_FU-1:0][3:0]     count_reg;
    logic [NUM_FU-1:0][3:0]     count_next;
    logic [NUM_FU-1:0]          fu_inc;
    logic [NUM_FU-1:0]          fu_dec;
    logic [NUM_FU-1:0]          fu_nonzero;
    logic [NUM_FU-1:0]          fu_busy_reg;
    logic                       sb_err_reg;
    logic                       sb_err_next;
    logic [3:0]                 cnt_sel;
    logic [3:0]                 cap_sel;
    logic [31:0]                fu_ext;
    logic                       fu_bad;
    logic                       raw_haz;
    logic                       waw_haz;
    logic                       struct_haz;
    logic                       rd_set;

    // A same-cycle writeback hides the pending bit, matching WB->EXU forwarding.
    assign pend_eff = pending_reg & ~wb_hit;

    // Select the occupancy count and capacity of the addressed FU.
    always_comb begin
        cnt_sel = '0;
        cap_sel = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (iss_fu == FU_W'(i)) begin
                cnt_sel = count_reg[i];
                cap_sel = FU_CAP[i*4 +: 4];
            end
        end
    end

    assign fu_ext = {{(32-FU_W){1'b0}}, iss_fu};
    assign fu_bad = iss_valid & (fu_ext >= NUM_FU);

    // Hazard evaluation and issue handshake.
    always_comb begin
        raw_haz    = (iss_rs1_en & (iss_rs1_addr != '0) & pend_eff[iss_rs1_addr]) |
                     (iss_rs2_en & (iss_rs2_addr != '0) & pend_eff[iss_rs2_addr]);
        waw_haz    = iss_rd_en & (iss_rd_addr != '0) & pend_eff[iss_rd_addr];
        // Capacity check uses the registered count: completions this cycle
        // do not free a slot until the next cycle.
        struct_haz = fu_bad | (cnt_sel == cap_sel);
        pipe_stall = iss_valid & (raw_haz | waw_haz | struct_haz);
        iss_fire   = iss_valid & ~pipe_stall & ~pipe_flush;
        rd_set     = iss_fire & iss_rd_en & (iss_rd_addr != '0);
    end

    // Per-register set/clear; a set from issue wins over a same-cycle clear.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wb_hit[gi]  = wb_valid & (wb_rd_addr == REG_FILE_ADDR_WIDTH'(gi));
            assign set_hit[gi] = rd_set & (iss_rd_addr == REG_FILE_ADDR_WIDTH'(gi));
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_nz
                assign pending_next[gi] = set_hit[gi] | (pending_reg[gi] & ~wb_hit[gi]);
            end
        end
    endgenerate

    // Per-FU occupancy counters; completions on an empty FU are dropped.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
            assign fu_nonzero[gi] = (count_reg[gi] != 4'd0);
            assign fu_inc[gi]     = iss_fire & (iss_fu == FU_W'(gi));
            assign fu_dec[gi]     = fu_done[gi] & fu_nonzero[gi];
            assign count_next[gi] = (fu_inc[gi] & ~fu_dec[gi]) ? count_reg[gi] + 4'd1 :
                                    (fu_dec[gi] & ~fu_inc[gi]) ? count_reg[gi] - 4'd1 :
                                                                 count_reg[gi];
        end
    endgenerate

    // Sticky error: spurious completion or an out-of-range FU index.
    assign sb_err_next = sb_err_reg | fu_bad | (|(fu_done & ~fu_nonzero));

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_reg <= '0;
            count_reg   <= '0;
            fu_busy_reg <= '0;
            sb_err_reg  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            count_reg   <= count_next;
            for (int i = 0; i < NUM_FU; i++) begin
                fu_busy_reg[i] <= (count_next[i] != 4'd0);
            end
            sb_err_reg  <= sb_err_next;
        end
    end

    assign pending = pending_reg;
    assign fu_busy = fu_busy_reg;
    assign sb_err  = sb_err_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (LSU capacity 4, other FUs capacity 1).
module tb_issue_scoreboard;

    logic        clk;
    logic        rstn;
    logic        iss_valid;
    logic [1:0]  iss_fu;
    logic        iss_rs1_en;
    logic [4:0]  iss_rs1_addr;
    logic        iss_rs2_en;
    logic [4:0]  iss_rs2_addr;
    logic        iss_rd_en;
    logic [4:0]  iss_rd_addr;
    logic        pipe_flush;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [3:0]  fu_done;
    logic        pipe_stall;
    logic        iss_fire;
    logic [3:0]  fu_busy;
    logic [31:0] pending;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    issue_scoreboard #(
        .NUM_REGS (32),
        .NUM_FU   (4),
        .FU_CAP   ({4'd4, 4'd1, 4'd1, 4'd1})
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .iss_valid    (iss_valid),
        .iss_fu       (iss_fu),
        .iss_rs1_en   (iss_rs1_en),
        .iss_rs1_addr (iss_rs1_addr),
        .iss_rs2_en   (iss_rs2_en),
        .iss_rs2_addr (iss_rs2_addr),
        .iss_rd_en    (iss_rd_en),
        .iss_rd_addr  (iss_rd_addr),
        .pipe_flush   (pipe_flush),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .fu_done      (fu_done),
        .pipe_stall   (pipe_stall),
        .iss_fire     (iss_fire),
        .fu_busy      (fu_busy),
        .pending      (pending),
        .sb_err       (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        iss_valid = 0; iss_fu = 0; iss_rs1_en = 0; iss_rs1_addr = 0;
        iss_rs2_en = 0; iss_rs2_addr = 0; iss_rd_en = 0; iss_rd_addr = 0;
        pipe_flush = 0; wb_valid = 0; wb_rd_addr = 0; fu_done = 0;
    endtask

    task automatic set_issue(input logic [1:0] fu, input logic [4:0] rs1, input logic rs1_en,
                             input logic [4:0] rd, input logic rd_en);
        iss_valid = 1; iss_fu = fu; iss_rs1_en = rs1_en; iss_rs1_addr = rs1;
        iss_rd_en = rd_en; iss_rd_addr = rd;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 0;
        #12;
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'h0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pending=%h fu_busy=%b sb_err=%b expected 0/0/0", pending, fu_busy, sb_err);
        end
        checks++;
        if (pipe_stall !== 1'b0 || iss_fire !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: stall=%b fire=%b expected 0/0", pipe_stall, iss_fire);
        end
        @(negedge clk); rstn = 1;
        $display("reset: pending=%h fu_busy=%b sb_err=%b", pending, fu_busy, sb_err);
    endtask

    task automatic test_issue_mul();
        @(negedge clk); set_issue(2'd1, 5'd0, 0, 5'd5, 1);
        #1;
        checks++;
        if (iss_fire !== 1'b1 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL mul_issue: fire=%b stall=%b expected 1/0", iss_fire, pipe_stall);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0000_0020 || fu_busy !== 4'b0010) begin
            errors++;
            $display("FAIL mul_state: pending=%h fu_busy=%b expected 00000020/0010", pending, fu_busy);
        end
        // second MUL with no register hazard: capacity 1 is full
        @(negedge clk); set_issue(2'd1, 5'd0, 0, 5'd20, 1);
        #1;
        checks++;
        if (pipe_stall !== 1'b1 || iss_fire !== 1'b0) begin
            errors++;
            $display("FAIL mul_struct: stall=%b fire=%b expected 1/0", pipe_stall, iss_fire);
        end
        $display("issue_mul: fire/stall checked, pending=%h", pending);
        idle_inputs();
    endtask

    task automatic test_raw_fwd();
        @(negedge clk); set_issue(2'd0, 5'd5, 1, 5'd6, 1);
        #1;
        checks++;
        if (pipe_stall !== 1'b1 || iss_fire !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall: stall=%b fire=%b expected 1/0", pipe_stall, iss_fire);
        end
        wb_valid = 1; wb_rd_addr = 5'd5; fu_done = 4'b0010;
        #1;
        checks++;
        if (pipe_stall !== 1'b0 || iss_fire !== 1'b1) begin
            errors++;
            $display("FAIL raw_forward: stall=%b fire=%b expected 0/1", pipe_stall, iss_fire);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0000_0040 || fu_busy !== 4'b0001) begin
            errors++;
            $display("FAIL raw_state: pending=%h fu_busy=%b expected 00000040/0001", pending, fu_busy);
        end
        @(negedge clk); wb_valid = 1; wb_rd_addr = 5'd6; fu_done = 4'b0001;
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'h0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL raw_retire: pending=%h fu_busy=%b sb_err=%b expected 0/0/0", pending, fu_busy, sb_err);
        end
        $display("raw_fwd: pending=%h fu_busy=%b", pending, fu_busy);
    endtask

    task automatic test_struct_lsu();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); set_issue(2'd3, 5'd0, 0, 5'(10 + k), 1);
            #1;
            checks++;
            if (iss_fire !== 1'b1) begin
                errors++;
                $display("FAIL lsu_issue%0d: fire=%b expected 1", k, iss_fire);
            end
            @(posedge clk); #1; idle_inputs();
        end
        checks++;
        if (pending !== 32'h0000_3C00 || fu_busy !== 4'b1000) begin
            errors++;
            $display("FAIL lsu_state: pending=%h fu_busy=%b expected 00003c00/1000", pending, fu_busy);
        end
        // WAW: ALU write to a register still pending
        @(negedge clk); set_issue(2'd0, 5'd0, 0, 5'd10, 1);
        #1;
        checks++;
        if (pipe_stall !== 1'b1 || iss_fire !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: stall=%b fire=%b expected 1/0", pipe_stall, iss_fire);
        end
        // fifth LSU op: full, and a completion this cycle does not help yet
        set_issue(2'd3, 5'd0, 0, 5'd14, 1);
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL lsu_full: stall=%b expected 1", pipe_stall);
        end
        fu_done = 4'b1000;
        #1;
        checks++;
        if (pipe_stall !== 1'b1 || iss_fire !== 1'b0) begin
            errors++;
            $display("FAIL lsu_no_credit: stall=%b fire=%b expected 1/0", pipe_stall, iss_fire);
        end
        @(posedge clk); #1; fu_done = 4'b0000;
        checks++;
        if (pipe_stall !== 1'b0 || iss_fire !== 1'b1) begin
            errors++;
            $display("FAIL lsu_after_credit: stall=%b fire=%b expected 0/1", pipe_stall, iss_fire);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0000_7C00 || fu_busy !== 4'b1000) begin
            errors++;
            $display("FAIL lsu_state5: pending=%h fu_busy=%b expected 00007c00/1000", pending, fu_busy);
        end
        // drain: four completions and five writebacks
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wb_valid = 1; wb_rd_addr = 5'(10 + k);
            fu_done = (k < 4) ? 4'b1000 : 4'b0000;
            @(posedge clk); #1; idle_inputs();
        end
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'h0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL lsu_drain: pending=%h fu_busy=%b sb_err=%b expected 0/0/0", pending, fu_busy, sb_err);
        end
        $display("struct_lsu: pending=%h fu_busy=%b", pending, fu_busy);
    endtask

    task automatic test_set_wins();
        @(negedge clk); set_issue(2'd0, 5'd0, 0, 5'd7, 1);
        wb_valid = 1; wb_rd_addr = 5'd7;
        #1;
        checks++;
        if (iss_fire !== 1'b1) begin
            errors++;
            $display("FAIL setwin_fire: fire=%b expected 1", iss_fire);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0000_0080) begin
            errors++;
            $display("FAIL setwin_pending: pending=%h expected 00000080", pending);
        end
        @(negedge clk); wb_valid = 1; wb_rd_addr = 5'd7; fu_done = 4'b0001;
        @(posedge clk); #1; idle_inputs();
        $display("set_wins: pending=%h", pending);
    endtask

    task automatic test_reg0();
        @(negedge clk); set_issue(2'd0, 5'd0, 1, 5'd0, 1);
        #1;
        checks++;
        if (iss_fire !== 1'b1) begin
            errors++;
            $display("FAIL reg0_fire: fire=%b expected 1", iss_fire);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'b0001) begin
            errors++;
            $display("FAIL reg0_state: pending=%h fu_busy=%b expected 0/0001", pending, fu_busy);
        end
        @(negedge clk); fu_done = 4'b0001; wb_valid = 1; wb_rd_addr = 5'd0;
        @(posedge clk); #1; idle_inputs();
        $display("reg0: pending=%h fu_busy=%b", pending, fu_busy);
    endtask

    task automatic test_flush();
        @(negedge clk); set_issue(2'd0, 5'd0, 0, 5'd9, 1); pipe_flush = 1;
        #1;
        checks++;
        if (iss_fire !== 1'b0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_comb: fire=%b stall=%b expected 0/0", iss_fire, pipe_stall);
        end
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'h0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: pending=%h fu_busy=%b sb_err=%b expected 0/0/0", pending, fu_busy, sb_err);
        end
        $display("flush: pending=%h", pending);
    endtask

    task automatic test_sb_err();
        @(negedge clk); fu_done = 4'b0100;
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (sb_err !== 1'b1 || fu_busy !== 4'h0) begin
            errors++;
            $display("FAIL err_set: sb_err=%b fu_busy=%b expected 1/0", sb_err, fu_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: sb_err=%b expected 1", sb_err);
        end
        $display("sb_err: sb_err=%b", sb_err);
    endtask

    task automatic test_async_reset();
        @(negedge clk); set_issue(2'd1, 5'd0, 0, 5'd3, 1);
        @(posedge clk); #1; idle_inputs();
        checks++;
        if (pending !== 32'h0000_0008 || fu_busy !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset: pending=%h fu_busy=%b expected 00000008/0010", pending, fu_busy);
        end
        #2; rstn = 0;
        #1;
        checks++;
        if (pending !== 32'h0 || fu_busy !== 4'h0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pending=%h fu_busy=%b sb_err=%b expected 0/0/0", pending, fu_busy, sb_err);
        end
        @(negedge clk); rstn = 1;
        @(negedge clk); set_issue(2'd1, 5'd0, 0, 5'd4, 1);
        #1;
        checks++;
        if (iss_fire !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_issue: fire=%b expected 1", iss_fire);
        end
        @(posedge clk); #1; idle_inputs();
        $display("async_reset: pending=%h fu_busy=%b", pending, fu_busy);
    endtask

    initial begin
        test_reset();
        test_issue_mul();
        test_raw_fwd();
        test_struct_lsu();
        test_set_wins();
        test_reg0();
        test_flush();
        test_sb_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
